// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - op codes and flag layout shared by the datapath and its ALU
package datapath_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOR = 3'b101;
   localparam logic [2:0] OP_SLT = 3'b110;
   localparam logic [2:0] OP_SLL = 3'b111;

   typedef struct packed {
      logic zero;
      logic overflow;
      logic carry;
      logic negative;
   } flags_t;

endpackage

// File: rtl/alu_w.sv
// rtl/alu_w.sv - combinational WIDTH-bit ALU with zero/overflow/carry/negative flags
module alu_w
   import datapath_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             overflow,
   output logic             carry,
   output logic             negative
);

   localparam int AW_SH = $clog2(WIDTH);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] dif;

   // SUB carry is the no-borrow bit of a + ~b + 1
   assign sum = {1'b0, a} + {1'b0, b};
   assign dif = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

   always_comb begin
      y        = '0;
      carry    = 1'b0;
      overflow = 1'b0;
      case (op)
         OP_ADD: begin
            y        = sum[WIDTH-1:0];
            carry    = sum[WIDTH];
            overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            y        = dif[WIDTH-1:0];
            carry    = dif[WIDTH];
            overflow = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NOR:  y = ~(a | b);
         OP_SLT:  y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLL:  y = a << b[AW_SH-1:0];
         default: y = '0;
      endcase
   end

   assign zero     = (y == '0);
   assign negative = y[WIDTH-1];

endmodule

// File: rtl/pipelined_datapath.sv
// rtl/pipelined_datapath.sv - two-stage EX/WB register-file ALU datapath with WB-to-EX forwarding
module pipelined_datapath
   import datapath_pkg::*;
#(
   parameter  int WIDTH    = 32,
   parameter  int NREG     = 4,
   parameter  int ZERO_REG = 1,
   localparam int AW       = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       alu_ctrl,
   input  logic [AW-1:0]    addr1,
   input  logic [AW-1:0]    addr2,
   input  logic [AW-1:0]    addr3,
   input  logic             wr,
   input  logic             use_imm,
   input  logic [WIDTH-1:0] imm,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             carry,
   output logic             negative,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   logic [WIDTH-1:0] rf [NREG];

   logic             ex_valid;
   logic [2:0]       ex_op;
   logic [AW-1:0]    ex_a1;
   logic [AW-1:0]    ex_a2;
   logic [AW-1:0]    ex_a3;
   logic             ex_wr;
   logic             ex_use_imm;
   logic [WIDTH-1:0] ex_imm;

   logic             wb_valid;
   logic [WIDTH-1:0] wb_result;
   flags_t           wb_flags;
   logic [AW-1:0]    wb_dest;
   logic             wb_wr;

   logic             stall;
   logic             accept;
   logic             wb_commits;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] alu_y;
   flags_t           alu_flags;

   assign stall     = wb_valid & ~res_ready;
   assign cmd_ready = ~stall;
   assign accept    = cmd_valid & cmd_ready;

   // A WB entry that will really land in the regfile; also the forwarding qualifier
   assign wb_commits = wb_valid & wb_wr & ~((ZERO_REG != 0) && (wb_dest == '0));

   always_comb begin
      op_a = rf[ex_a1];
      if (wb_commits && (wb_dest == ex_a1))
         op_a = wb_result;
      op_b = rf[ex_a2];
      if (ex_use_imm)
         op_b = ex_imm;
      else if (wb_commits && (wb_dest == ex_a2))
         op_b = wb_result;
   end

   alu_w #(.WIDTH(WIDTH)) u_alu (
      .a        (op_a),
      .b        (op_b),
      .op       (ex_op),
      .y        (alu_y),
      .zero     (alu_flags.zero),
      .overflow (alu_flags.overflow),
      .carry    (alu_flags.carry),
      .negative (alu_flags.negative)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_valid   <= 1'b0;
         ex_op      <= '0;
         ex_a1      <= '0;
         ex_a2      <= '0;
         ex_a3      <= '0;
         ex_wr      <= 1'b0;
         ex_use_imm <= 1'b0;
         ex_imm     <= '0;
      end else if (!stall) begin
         ex_valid <= accept;
         if (accept) begin
            ex_op      <= alu_ctrl;
            ex_a1      <= addr1;
            ex_a2      <= addr2;
            ex_a3      <= addr3;
            ex_wr      <= wr;
            ex_use_imm <= use_imm;
            ex_imm     <= imm;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_valid  <= 1'b0;
         wb_result <= '0;
         wb_flags  <= '0;
         wb_dest   <= '0;
         wb_wr     <= 1'b0;
      end else if (!stall) begin
         wb_valid <= ex_valid;
         if (ex_valid) begin
            wb_result <= alu_y;
            wb_flags  <= alu_flags;
            wb_dest   <= ex_a3;
            wb_wr     <= ex_wr;
         end
      end
   end

   // Retire-edge write; a command issued on the same edge reads the new value next cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++)
            rf[i] <= '0;
      end else if (wb_commits && res_ready) begin
         rf[wb_dest] <= wb_result;
      end
   end

   assign res_valid = wb_valid;
   assign result    = wb_result;
   assign zero      = wb_flags.zero;
   assign overflow  = wb_flags.overflow;
   assign carry     = wb_flags.carry;
   assign negative  = wb_flags.negative;
   assign dbg_data  = rf[dbg_addr];

endmodule

// File: tb/tb_pipelined_datapath.sv
// tb/tb_pipelined_datapath.sv - directed self-checking bench for pipelined_datapath
module tb_pipelined_datapath;
   import datapath_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  alu_ctrl;
   logic [1:0]  addr1, addr2, addr3;
   logic        wr;
   logic        use_imm;
   logic [31:0] imm;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] result;
   logic        zero, overflow, carry, negative;
   logic [1:0]  dbg_addr;
   logic [31:0] dbg_data;

   int tests = 0;
   int fails = 0;

   pipelined_datapath #(.WIDTH(32), .NREG(4), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .alu_ctrl(alu_ctrl), .addr1(addr1), .addr2(addr2), .addr3(addr3),
      .wr(wr), .use_imm(use_imm), .imm(imm), .res_valid(res_valid),
      .res_ready(res_ready), .result(result), .zero(zero), .overflow(overflow),
      .carry(carry), .negative(negative), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic v, input logic [2:0] op, input logic [1:0] a1,
                        input logic [1:0] a2, input logic [1:0] a3, input logic w,
                        input logic ui, input logic [31:0] im);
      cmd_valid = v; alu_ctrl = op; addr1 = a1; addr2 = a2; addr3 = a3;
      wr = w; use_imm = ui; imm = im;
   endtask

   task automatic test_reset;
      rst = 1'b0; res_ready = 1'b1; dbg_addr = 2'd0;
      drive(1'b0, OP_ADD, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 32'h0);
      #12;
      tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
      tests++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result got=%h exp=0", result); end
      tests++; if ({zero, overflow, carry, negative} !== 4'b0) begin fails++; $display("FAIL reset_flags got=%b exp=0000", {zero, overflow, carry, negative}); end
      @(negedge clk); rst = 1'b1; #1;
      tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
      for (int i = 0; i < 4; i++) begin
         dbg_addr = 2'(i); #1;
         tests++; if (dbg_data !== 32'h0) begin fails++; $display("FAIL reset_reg%0d got=%h exp=0", i, dbg_data); end
      end
   endtask

   task automatic test_load;
      @(negedge clk); drive(1'b1, OP_ADD, 2'd0, 2'd0, 2'd1, 1'b1, 1'b1, 32'h0000_00F0);
      @(posedge clk); #1;
      tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL load_latency got=%b exp=0", res_valid); end
      @(negedge clk); drive(1'b1, OP_ADD, 2'd0, 2'd0, 2'd2, 1'b1, 1'b1, 32'h0000_000F);
      @(posedge clk); #1;
      tests++; if (res_valid !== 1'b1 || result !== 32'hF0) begin fails++; $display("FAIL load_r1 got=%b/%h exp=1/000000f0", res_valid, result); end
      @(negedge clk); cmd_valid = 1'b0; dbg_addr = 2'd1;
      @(posedge clk); #1;
      tests++; if (result !== 32'h0F || zero !== 1'b0) begin fails++; $display("FAIL load_r2 got=%h z=%b exp=0000000f z=0", result, zero); end
      tests++; if (dbg_data !== 32'hF0) begin fails++; $display("FAIL load_dbg_r1 got=%h exp=000000f0", dbg_data); end
      @(posedge clk); #1; dbg_addr = 2'd2; #1;
      tests++; if (res_valid !== 1'b0 || dbg_data !== 32'h0F) begin fails++; $display("FAIL load_retire got=%b/%h exp=0/0000000f", res_valid, dbg_data); end
   endtask

   task automatic test_back_to_back;
      @(negedge clk); drive(1'b1, OP_AND, 2'd1, 2'd2, 2'd3, 1'b1, 1'b0, 32'h0);
      @(posedge clk);
      @(negedge clk); drive(1'b1, OP_OR, 2'd1, 2'd3, 2'd1, 1'b1, 1'b0, 32'h0);
      @(posedge clk); #1;
      tests++; if (result !== 32'h0 || zero !== 1'b1) begin fails++; $display("FAIL b2b_and got=%h z=%b exp=00000000 z=1", result, zero); end
      @(negedge clk); drive(1'b1, OP_ADD, 2'd0, 2'd0, 2'd3, 1'b1, 1'b1, 32'h55);
      @(posedge clk); #1;
      tests++; if (result !== 32'hF0 || zero !== 1'b0) begin fails++; $display("FAIL b2b_or got=%h z=%b exp=000000f0 z=0", result, zero); end
      @(negedge clk); drive(1'b1, OP_ADD, 2'd3, 2'd0, 2'd2, 1'b1, 1'b1, 32'h1);
      @(posedge clk); #1;
      tests++; if (result !== 32'h55) begin fails++; $display("FAIL b2b_load_r3 got=%h exp=00000055", result); end
      @(negedge clk); cmd_valid = 1'b0;
      @(posedge clk); #1;
      tests++; if (result !== 32'h56) begin fails++; $display("FAIL b2b_forward got=%h exp=00000056", result); end
      @(posedge clk); #1; dbg_addr = 2'd2; #1;
      tests++; if (dbg_data !== 32'h56) begin fails++; $display("FAIL b2b_dbg_r2 got=%h exp=00000056", dbg_data); end
   endtask

   task automatic test_flags;
      @(negedge clk); drive(1'b1, OP_ADD, 2'd0, 2'd0, 2'd1, 1'b1, 1'b1, 32'h7FFF_FFFF);
      @(posedge clk);
      @(negedge clk); drive(1'b1, OP_ADD, 2'd1, 2'd0, 2'd2, 1'b1, 1'b1, 32'h1);
      @(posedge clk); #1;
      tests++; if (result !== 32'h7FFF_FFFF || overflow !== 1'b0) begin fails++; $display("FAIL flags_load got=%h v=%b exp=7fffffff v=0", result, overflow); end
      @(negedge clk); drive(1'b1, OP_SUB, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 32'h1);
      @(posedge clk); #1;
      tests++; if (result !== 32'h8000_0000 || {zero, overflow, carry, negative} !== 4'b0101) begin fails++; $display("FAIL flags_add_ovf got=%h zvcn=%b exp=80000000 zvcn=0101", result, {zero, overflow, carry, negative}); end
      @(negedge clk); drive(1'b1, OP_SLT, 2'd2, 2'd1, 2'd0, 1'b0, 1'b0, 32'h0);
      @(posedge clk); #1;
      tests++; if (result !== 32'hFFFF_FFFF || {zero, overflow, carry, negative} !== 4'b0001) begin fails++; $display("FAIL flags_sub_borrow got=%h zvcn=%b exp=ffffffff zvcn=0001", result, {zero, overflow, carry, negative}); end
      @(negedge clk); drive(1'b1, OP_SLL, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1, 32'h4);
      @(posedge clk); #1;
      tests++; if (result !== 32'h1 || {zero, overflow, carry, negative} !== 4'b0000) begin fails++; $display("FAIL flags_slt got=%h zvcn=%b exp=00000001 zvcn=0000", result, {zero, overflow, carry, negative}); end
      @(negedge clk); drive(1'b1, OP_SUB, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1, 32'h1);
      @(posedge clk); #1;
      tests++; if (result !== 32'hFFFF_FFF0 || {overflow, carry} !== 2'b00) begin fails++; $display("FAIL flags_sll got=%h vc=%b exp=fffffff0 vc=00", result, {overflow, carry}); end
      @(negedge clk); cmd_valid = 1'b0;
      @(posedge clk); #1;
      tests++; if (result !== 32'h7FFF_FFFE || {zero, overflow, carry, negative} !== 4'b0010) begin fails++; $display("FAIL flags_sub_carry got=%h zvcn=%b exp=7ffffffe zvcn=0010", result, {zero, overflow, carry, negative}); end
      @(posedge clk);
   endtask

   task automatic test_stall;
      @(negedge clk); res_ready = 1'b0; drive(1'b1, OP_ADD, 2'd0, 2'd0, 2'd3, 1'b1, 1'b1, 32'h11);
      @(posedge clk);
      @(negedge clk); drive(1'b1, OP_ADD, 2'd3, 2'd0, 2'd1, 1'b1, 1'b1, 32'h1);
      @(posedge clk); #1;
      tests++; if (cmd_ready !== 1'b0 || res_valid !== 1'b1 || result !== 32'h11) begin fails++; $display("FAIL stall_enter got=rdy%b v%b %h exp=rdy0 v1 00000011", cmd_ready, res_valid, result); end
      @(negedge clk); cmd_valid = 1'b0; dbg_addr = 2'd3;
      repeat (2) @(posedge clk);
      #1;
      tests++; if (result !== 32'h11 || res_valid !== 1'b1) begin fails++; $display("FAIL stall_hold got=%b/%h exp=1/00000011", res_valid, result); end
      tests++; if (dbg_data !== 32'h55) begin fails++; $display("FAIL stall_no_write got=%h exp=00000055", dbg_data); end
      @(negedge clk); res_ready = 1'b1; #1;
      tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL stall_release_ready got=%b exp=1", cmd_ready); end
      @(posedge clk); #1;
      tests++; if (result !== 32'h12 || dbg_data !== 32'h11) begin fails++; $display("FAIL stall_retire_a got=%h r3=%h exp=00000012 r3=00000011", result, dbg_data); end
      @(posedge clk); #1; dbg_addr = 2'd1; #1;
      tests++; if (res_valid !== 1'b0 || dbg_data !== 32'h12) begin fails++; $display("FAIL stall_retire_b got=%b r1=%h exp=0 r1=00000012", res_valid, dbg_data); end
   endtask

   task automatic test_zero_reg;
      @(negedge clk); drive(1'b1, OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 32'h5);
      @(posedge clk);
      @(negedge clk); drive(1'b1, OP_ADD, 2'd0, 2'd0, 2'd2, 1'b1, 1'b1, 32'h3);
      @(posedge clk); #1;
      tests++; if (result !== 32'h5) begin fails++; $display("FAIL zreg_result got=%h exp=00000005", result); end
      @(negedge clk); cmd_valid = 1'b0; dbg_addr = 2'd0;
      @(posedge clk); #1;
      tests++; if (result !== 32'h3) begin fails++; $display("FAIL zreg_no_forward got=%h exp=00000003", result); end
      tests++; if (dbg_data !== 32'h0) begin fails++; $display("FAIL zreg_dbg_r0 got=%h exp=0", dbg_data); end
      @(posedge clk);
   endtask

   task automatic test_reset_mid;
      @(negedge clk); res_ready = 1'b0; drive(1'b1, OP_ADD, 2'd0, 2'd0, 2'd2, 1'b1, 1'b1, 32'hAB);
      @(posedge clk);
      @(negedge clk); cmd_valid = 1'b0; dbg_addr = 2'd2;
      @(posedge clk); #1;
      tests++; if (res_valid !== 1'b1 || result !== 32'hAB) begin fails++; $display("FAIL rmid_pending got=%b/%h exp=1/000000ab", res_valid, result); end
      #2; rst = 1'b0; #1;
      tests++; if (res_valid !== 1'b0 || result !== 32'h0) begin fails++; $display("FAIL rmid_async got=%b/%h exp=0/00000000", res_valid, result); end
      @(negedge clk); rst = 1'b1; res_ready = 1'b1; #1;
      tests++; if (dbg_data !== 32'h0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL rmid_after got=%h rdy=%b exp=00000000 rdy=1", dbg_data, cmd_ready); end
      @(posedge clk); #1;
      tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL rmid_flushed got=%b exp=0", res_valid); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_back_to_back();
      test_flags();
      test_stall();
      test_zero_reg();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipelined_datapath.md
Name: pipelined_datapath

Overview:
Parametrised two-stage register-file/ALU datapath. It is the successor to the fixed 4x32 single-cycle datapath. Commands (two source registers, one destination, ALU op, optional immediate) arrive through a valid/ready handshake, execute in an EX stage and retire from a WB stage that drives the result and flags. WB-to-EX forwarding lets back-to-back dependent commands issue every cycle. Output backpressure stalls the whole pipe.

Parameters:
WIDTH, 32, datapath and register width (>=8).
NREG, 4, number of registers (power of two, >=2); AW = $clog2(NREG) is a derived localparam.
ZERO_REG, 1, when 1, register 0 reads as 0 and writes to it are discarded.

Ports:
clk  in  1  clock, all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  pipeline can accept a command this cycle.
alu_ctrl  in  3  op code (see Behaviour).
addr1  in  AW  source A register.
addr2  in  AW  source B register.
addr3  in  AW  destination register.
wr  in  1  write the result to addr3 on retire.
use_imm  in  1  operand B = imm instead of reg[addr2].
imm  in  WIDTH  immediate operand.
res_valid  out  1  WB stage holds a result.
res_ready  in  1  consumer accepts the result.
result  out  WIDTH  WB result.
zero  out  1  result == 0.
overflow  out  1  signed overflow (ADD/SUB only).
carry  out  1  carry out (ADD) or no-borrow (SUB); 0 otherwise.
negative  out  1  result[WIDTH-1].
dbg_addr  in  AW  debug read address.
dbg_data  out  WIDTH  committed reg[dbg_addr], combinational, no forwarding.

Behaviour:
- Op codes:
  - 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 NOR.
  - 110 SLT: signed A<B gives 1, else 0.
  - 111 SLL: A << B[AW_SH-1:0], where AW_SH = $clog2(WIDTH).
  - Arithmetic is modulo 2^WIDTH.
- Reset (rst=0, asynchronous):
  - All registers, EX and WB valid bits and all outputs clear to 0.
  - cmd_ready = 1 once reset is released.
  - Reset asserted mid-operation discards in-flight commands with no register write.
- Handshake and stall:
  - Accept = cmd_valid & cmd_ready.
  - stall = res_valid & ~res_ready; cmd_ready = ~stall.
  - While stalled, the EX and WB stages hold their contents, and outputs stay stable.
- Timing for a command accepted at edge k:
  - Edge k: the command is latched into the EX register.
  - Cycle k..k+1: operands are read and the ALU computes.
  - Edge k+1: the result and flags are latched into WB; res_valid = 1.
  - Retire: the edge where res_valid & res_ready. At that edge the regfile is written (if wr, and not addr3==0 with ZERO_REG=1), and res_valid drops unless a new EX result moves in.
- Throughput: one command per cycle when res_ready is held high.
- Forwarding: if WB is valid with wr, and its dest == EX addr1 (or addr2 without use_imm), EX uses the WB result. This does not apply to register 0 when ZERO_REG=1.
- Retirement order: write-back at the retire edge happens before a later command reads the register from the regfile, so no second forwarding path is needed.
- Flags are computed in EX and registered with the result.
- wr=0 commands still produce a result and flags but write nothing.

Decomposition:
- Shared package datapath_pkg: op-code localparams (OP_ADD..OP_SLL) and a flag-vector layout typedef {zero, overflow, carry, negative}.
- One sub-module alu_w: purely combinational, parametrised by WIDTH. Inputs a, b, op; outputs y, zero, overflow, carry, negative.
- The register file stays inline, with a combinational read and the write at retire.

Test Plan:
- Reset, then issue ADD r1=r0+imm 0x0000_00F0 and ADD r2=r0+imm 0x0000_000F with res_ready=1 -> results F0 and 0F, one cycle after each accept; dbg_data(r1)=F0.
- Back-to-back AND r3=r1&r2, then OR r1=r1|r3 issued on the next cycle -> AND result 0 with zero=1. The forwarded r3=0 gives OR result F0, zero=0.
- ADD imm 0x7FFF_FFFF + imm 1 through r0 (load r1=7FFFFFFF, then ADD r2=r1+imm 1) -> 8000_0000, overflow=1, negative=1, carry=0. SUB r0-imm 1 -> FFFF_FFFF, carry=0, overflow=0.
- Hold res_ready=0 with two commands in flight -> cmd_ready=0, result stable and no regfile write. Raise res_ready -> the two commands retire on consecutive edges in order.
- Write to r0 with ZERO_REG=1 (ADD r0=r0+imm 5, wr=1) -> result 5, but dbg_data(r0) stays 0 and a following read of r0 gives 0 (no forwarding).
- Assert rst low while WB holds an uncommitted write to r2 -> res_valid=0 immediately; after release dbg_data(r2)=0.
